// File: rtl/ram_arb_pkg.sv
// Shared types for the CPU/loader RAM port arbiter.
// Optional perf counters are enabled with `RAM_ARB_PERF_EN (see ram_port_arbiter).
package ram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_LDR  = 2'd2
  } owner_e;

  typedef enum logic {
    SEL_CPU = 1'b0,
    SEL_LDR = 1'b1
  } sel_e;

endpackage

// File: rtl/ram_arb_fsm.sv
// Ownership tracker for the RAM arbiter: remembers the last grantee and how many
// consecutive grants it has had, and picks the winner for the current cycle.
module ram_arb_fsm
  import ram_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   cpu_req_i,
  input  logic   ldr_req_i,
  output logic   gnt_valid_o,
  output sel_e   sel_o,
  output owner_e owner_o
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  owner_e           winner;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q   <= OWN_NONE;
      run_cnt_q <= '0;
    end else begin
      owner_q   <= owner_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  always_comb begin
    gnt_valid_o = cpu_req_i | ldr_req_i;
    sel_o       = SEL_CPU;
    winner      = OWN_NONE;
    owner_d     = OWN_NONE;
    run_cnt_d   = '0;

    // Under contention the current owner keeps the RAM until its burst is used up.
    if (cpu_req_i && ldr_req_i) begin
      if (owner_q == OWN_NONE)
        sel_o = SEL_CPU;
      else if (run_cnt_q < CNT_MAX)
        sel_o = (owner_q == OWN_LDR) ? SEL_LDR : SEL_CPU;
      else
        sel_o = (owner_q == OWN_CPU) ? SEL_LDR : SEL_CPU;
    end else if (ldr_req_i) begin
      sel_o = SEL_LDR;
    end

    if (gnt_valid_o) begin
      winner  = (sel_o == SEL_LDR) ? OWN_LDR : OWN_CPU;
      owner_d = winner;
      if (winner == owner_q)
        run_cnt_d = (run_cnt_q == CNT_MAX) ? run_cnt_q : run_cnt_q + 1'b1;
      else
        run_cnt_d = CNT_W'(1);
    end
  end

  assign owner_o = owner_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between the CPU and a loader/DMA port.
// Define RAM_ARB_PERF_EN to add grant/stall performance counters.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4,
  parameter int PERF_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output owner_e            dbg_owner,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef RAM_ARB_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_cpu_gnt,
  output logic [PERF_W-1:0] perf_ldr_gnt,
  output logic [PERF_W-1:0] perf_cpu_stall
`endif
);

  // Handshake: a requester holds req (and its we/addr/wdata) until it sees gnt in
  // the same cycle; a granted read returns data with a one-cycle rvalid pulse on
  // the following cycle. There is no back-pressure on rvalid.

  logic fsm_gnt;
  sel_e sel;

  ram_arb_fsm #(
    .MAX_BURST(MAX_BURST)
  ) u_fsm (
    .clk        (clk),
    .reset      (reset),
    .cpu_req_i  (cpu_req),
    .ldr_req_i  (ldr_req),
    .gnt_valid_o(fsm_gnt),
    .sel_o      (sel),
    .owner_o    (dbg_owner)
  );

  // Reset masks the grant so nothing reaches the RAM while the arbiter clears.
  assign cpu_gnt   = ~reset & fsm_gnt & (sel == SEL_CPU);
  assign ldr_gnt   = ~reset & fsm_gnt & (sel == SEL_LDR);
  assign cpu_stall = cpu_req & ~cpu_gnt;

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    if (cpu_gnt) begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_we;
    end else if (ldr_gnt) begin
      ram_addr  = ldr_addr;
      ram_wdata = ldr_wdata;
      ram_we    = ldr_we;
    end
  end

  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              ldr_rvalid_q, ldr_rvalid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;

  always_comb begin
    cpu_rvalid_d = cpu_gnt & ~cpu_we;
    ldr_rvalid_d = ldr_gnt & ~ldr_we;
    cpu_rdata_d  = cpu_rvalid_d ? ram_rdata : cpu_rdata_q;
    ldr_rdata_d  = ldr_rvalid_d ? ram_rdata : ldr_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rvalid_q <= 1'b0;
      ldr_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      ldr_rdata_q  <= '0;
    end else begin
      cpu_rvalid_q <= cpu_rvalid_d;
      ldr_rvalid_q <= ldr_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ldr_rdata_q  <= ldr_rdata_d;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign ldr_rvalid = ldr_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign ldr_rdata  = ldr_rdata_q;

`ifdef RAM_ARB_PERF_EN
  logic [PERF_W-1:0] perf_cpu_gnt_q, perf_ldr_gnt_q, perf_cpu_stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cpu_gnt_q   <= '0;
      perf_ldr_gnt_q   <= '0;
      perf_cpu_stall_q <= '0;
    end else begin
      perf_cpu_gnt_q   <= perf_cpu_gnt_q + PERF_W'(cpu_gnt);
      perf_ldr_gnt_q   <= perf_ldr_gnt_q + PERF_W'(ldr_gnt);
      perf_cpu_stall_q <= perf_cpu_stall_q + PERF_W'(cpu_stall);
    end
  end

  assign perf_cpu_gnt   = perf_cpu_gnt_q;
  assign perf_ldr_gnt   = perf_ldr_gnt_q;
  assign perf_cpu_stall = perf_cpu_stall_q;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Table-driven bench for ram_port_arbiter with a read-data scoreboard; a second
// instance with MAX_BURST=1 covers strict alternation.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, ldr_req, ldr_we;
  logic [31:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata, ram_rdata;

  logic        cpu_gnt, cpu_stall, cpu_rvalid, ldr_gnt, ldr_rvalid, ram_we;
  logic [31:0] cpu_rdata, ldr_rdata, ram_addr, ram_wdata;
  owner_e      dbg_owner;

  logic        b_cpu_gnt, b_cpu_stall, b_cpu_rvalid, b_ldr_gnt, b_ldr_rvalid, b_ram_we;
  logic [31:0] b_cpu_rdata, b_ldr_rdata, b_ram_addr, b_ram_wdata;
  owner_e      b_dbg_owner;

  logic [31:0] perf_cpu_gnt, perf_ldr_gnt, perf_cpu_stall;
  logic [31:0] b_perf_cpu_gnt, b_perf_ldr_gnt, b_perf_cpu_stall;

  always #5 clk = ~clk;

  ram_port_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .dbg_owner(dbg_owner), .ram_rdata(ram_rdata)
`ifdef RAM_ARB_PERF_EN
    , .perf_cpu_gnt(perf_cpu_gnt), .perf_ldr_gnt(perf_ldr_gnt), .perf_cpu_stall(perf_cpu_stall)
`endif
  );

  ram_port_arbiter #(.MAX_BURST(1)) dut_b1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(b_cpu_gnt), .cpu_stall(b_cpu_stall), .cpu_rvalid(b_cpu_rvalid), .cpu_rdata(b_cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(b_ldr_gnt), .ldr_rvalid(b_ldr_rvalid), .ldr_rdata(b_ldr_rdata),
    .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_we(b_ram_we),
    .dbg_owner(b_dbg_owner), .ram_rdata(ram_rdata)
`ifdef RAM_ARB_PERF_EN
    , .perf_cpu_gnt(b_perf_cpu_gnt), .perf_ldr_gnt(b_perf_ldr_gnt), .perf_cpu_stall(b_perf_cpu_stall)
`endif
  );

  typedef struct {
    logic        rst;
    logic        creq, cwe;
    logic [31:0] caddr, cwd;
    logic        lreq, lwe;
    logic [31:0] laddr, lwd;
    logic [31:0] rrd;
    logic        e_cg, e_lg;
  } row_t;

  row_t        rows[$];
  logic [31:0] cpu_exp_q[$];
  logic [31:0] ldr_exp_q[$];
  logic [31:0] exp_cpu_rdata, exp_ldr_rdata;
  int          tests = 0;
  int          fails = 0;
  int          seg2_end;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic rst, input logic creq, input logic cwe,
                              input logic [31:0] caddr, input logic [31:0] cwd,
                              input logic lreq, input logic lwe,
                              input logic [31:0] laddr, input logic [31:0] lwd,
                              input logic [31:0] rrd, input logic ecg, input logic elg);
    row_t r;
    r.rst = rst; r.creq = creq; r.cwe = cwe; r.caddr = caddr; r.cwd = cwd;
    r.lreq = lreq; r.lwe = lwe; r.laddr = laddr; r.lwd = lwd; r.rrd = rrd;
    r.e_cg = ecg; r.e_lg = elg;
    rows.push_back(r);
  endfunction

  task automatic drive(input logic rst, input logic creq, input logic cwe, input logic [31:0] caddr,
                       input logic [31:0] cwd, input logic lreq, input logic lwe,
                       input logic [31:0] laddr, input logic [31:0] lwd, input logic [31:0] rrd);
    reset = rst; cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    ldr_req = lreq; ldr_we = lwe; ldr_addr = laddr; ldr_wdata = lwd; ram_rdata = rrd;
  endtask

  task automatic apply_row(input int idx);
    row_t        r;
    logic [31:0] e_addr, e_wd;
    logic        e_we;
    owner_e      e_own;
    r = rows[idx];
    @(negedge clk);
    drive(r.rst, r.creq, r.cwe, r.caddr, r.cwd, r.lreq, r.lwe, r.laddr, r.lwd, r.rrd);
    #1;
    e_addr = r.e_cg ? r.caddr : (r.e_lg ? r.laddr : 32'h0);
    e_wd   = r.e_cg ? r.cwd   : (r.e_lg ? r.lwd   : 32'h0);
    e_we   = (r.e_cg & r.cwe) | (r.e_lg & r.lwe);
    chk($sformatf("row%0d cpu_gnt", idx), 64'(cpu_gnt), 64'(r.e_cg));
    chk($sformatf("row%0d ldr_gnt", idx), 64'(ldr_gnt), 64'(r.e_lg));
    chk($sformatf("row%0d cpu_stall", idx), 64'(cpu_stall), 64'(r.creq & ~r.e_cg));
    chk($sformatf("row%0d ram_we", idx), 64'(ram_we), 64'(e_we));
    chk($sformatf("row%0d ram_addr", idx), 64'(ram_addr), 64'(e_addr));
    chk($sformatf("row%0d ram_wdata", idx), 64'(ram_wdata), 64'(e_wd));
    if (r.e_cg && !r.cwe) begin cpu_exp_q.push_back(r.rrd); exp_cpu_rdata = r.rrd; end
    if (r.e_lg && !r.lwe) begin ldr_exp_q.push_back(r.rrd); exp_ldr_rdata = r.rrd; end
    if (r.rst) begin
      cpu_exp_q.delete(); ldr_exp_q.delete();
      exp_cpu_rdata = 32'h0; exp_ldr_rdata = 32'h0;
    end
    e_own = r.rst ? OWN_NONE : (r.e_cg ? OWN_CPU : (r.e_lg ? OWN_LDR : OWN_NONE));
    @(posedge clk);
    #1;
    chk($sformatf("row%0d owner", idx), 64'(dbg_owner), 64'(e_own));
    if (cpu_exp_q.size() > 0) begin
      chk($sformatf("row%0d cpu_rvalid", idx), 64'(cpu_rvalid), 64'd1);
      chk($sformatf("row%0d cpu_rdata", idx), 64'(cpu_rdata), 64'(cpu_exp_q.pop_front()));
    end else begin
      chk($sformatf("row%0d cpu_rvalid", idx), 64'(cpu_rvalid), 64'd0);
      chk($sformatf("row%0d cpu_rdata hold", idx), 64'(cpu_rdata), 64'(exp_cpu_rdata));
    end
    if (ldr_exp_q.size() > 0) begin
      chk($sformatf("row%0d ldr_rvalid", idx), 64'(ldr_rvalid), 64'd1);
      chk($sformatf("row%0d ldr_rdata", idx), 64'(ldr_rdata), 64'(ldr_exp_q.pop_front()));
    end else begin
      chk($sformatf("row%0d ldr_rvalid", idx), 64'(ldr_rvalid), 64'd0);
      chk($sformatf("row%0d ldr_rdata hold", idx), 64'(ldr_rdata), 64'(exp_ldr_rdata));
    end
  endtask

  initial begin
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_cpu_rdata = 32'h0;
    exp_ldr_rdata = 32'h0;
    repeat (2) @(posedge clk);

    // Reset with both requesting: nothing reaches the RAM.
    add(1, 1, 1, 32'h44, 32'h55, 1, 1, 32'h66, 32'h77, 32'h0, 0, 0);
    // CPU read.
    add(0, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 32'hDEADBEEF, 1, 0);
    add(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
    // Loader write: no rvalid, ldr_rdata stays put.
    add(0, 0, 0, 32'h0, 32'h0, 1, 1, 32'h20, 32'h1234, 32'h9999, 0, 1);
    add(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
    // Loader read, then CPU back-to-back reads.
    add(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h30, 32'h0, 32'hCAFE0001, 0, 1);
    for (int i = 0; i < 3; i++)
      add(0, 1, 0, 32'h40 + i, 32'h0, 0, 0, 32'h0, 32'h0, $urandom, 1, 0);
    // Fresh reset, then 12 cycles of contention with MAX_BURST=4.
    add(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      logic c;
      c = (i < 4) || (i >= 8);
      add(0, 1, 0, 32'h100 + i, 32'h0, 1, 1, 32'h200 + i, 32'(i), 32'hA0000000 + i, c, !c);
    end
    seg2_end = rows.size();
    add(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
    // CPU read grant, reset next cycle, then contention restarts with CPU.
    add(0, 1, 0, 32'h50, 32'h0, 0, 0, 32'h0, 32'h0, 32'h12345678, 1, 0);
    add(1, 1, 0, 32'h50, 32'h0, 1, 0, 32'h60, 32'h0, 32'h0, 0, 0);
    add(0, 1, 0, 32'h54, 32'h0, 1, 0, 32'h64, 32'h0, 32'h0BADF00D, 1, 0);
    // Loader owns the RAM when reset hits: after reset CPU still wins first.
    add(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h70, 32'h0, 32'h11112222, 0, 1);
    add(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
    add(0, 1, 1, 32'h80, 32'h5A5A, 1, 1, 32'h90, 32'hA5A5, 32'h0, 1, 0);
    // Dropping a request mid-burst: the remaining owner keeps priority.
    add(0, 1, 1, 32'h84, 32'h1, 1, 1, 32'h94, 32'h2, 32'h0, 1, 0);
    add(0, 0, 0, 32'h0, 32'h0, 1, 1, 32'h98, 32'h3, 32'h0, 0, 1);
    add(0, 1, 1, 32'h88, 32'h4, 1, 1, 32'h9C, 32'h5, 32'h0, 0, 1);

    for (int i = 0; i < rows.size(); i++) begin
      apply_row(i);
`ifdef RAM_ARB_PERF_EN
      if (i == seg2_end - 1) begin
        chk("perf_cpu_gnt", 64'(perf_cpu_gnt), 64'd8);
        chk("perf_ldr_gnt", 64'(perf_ldr_gnt), 64'd4);
        chk("perf_cpu_stall", 64'(perf_cpu_stall), 64'd4);
      end
`endif
    end

    // MAX_BURST=1 instance: strict alternation, then loader drops out.
    @(negedge clk);
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 32'h300 + i, 32'(i), (i < 6), 1'b1, 32'h400 + i, 32'(i), 32'h0);
      #1;
      chk($sformatf("b1 cyc%0d cpu_gnt", i), 64'(b_cpu_gnt), 64'((i >= 6) || (i % 2 == 0)));
      chk($sformatf("b1 cyc%0d ldr_gnt", i), 64'(b_ldr_gnt), 64'((i < 6) && (i % 2 == 1)));
    end
    @(negedge clk);
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("b1 owner idle", 64'(b_dbg_owner), 64'(OWN_NONE));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
